led_shift_ctrl: RTL and testbench

Command-driven controller for the 8-bit rotating LED pattern on the board. Accepts remote commands over a valid/ready interface to load, rotate, pause, single-step and retime the pattern. Generates its own rotation ticks from `CLK_FREQ`. Drives the `leds` pins directly.

---
 rtl/led_shift_ctrl_pkg.sv | 36 +++
 rtl/led_shift_ctrl_if.sv | 13 +
 rtl/led_tick_gen.sv | 38 +++
 rtl/led_shift_ctrl.sv | 147 ++++++++++++++
 tb/tb_led_shift_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/led_shift_ctrl_pkg.sv
// Shared constants, opcodes and helpers for the LED shift controller.
package led_ctrl_pkg;

    localparam int LED_W   = 8;
    localparam int OP_W    = 3;
    localparam int SPEED_W = 2;

    localparam logic [OP_W-1:0] OP_NOP       = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD      = 3'd1;
    localparam logic [OP_W-1:0] OP_RUN       = 3'd2;
    localparam logic [OP_W-1:0] OP_STOP      = 3'd3;
    localparam logic [OP_W-1:0] OP_STEP      = 3'd4;
    localparam logic [OP_W-1:0] OP_SET_DIR   = 3'd5;
    localparam logic [OP_W-1:0] OP_SET_SPEED = 3'd6;
    localparam logic [OP_W-1:0] OP_INVERT    = 3'd7;

    localparam logic [LED_W-1:0] RESET_PATTERN = 8'h1F;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } ctrl_state_e;

    // One-position circular rotation; left moves toward the MSB.
    function automatic logic [LED_W-1:0] rotate(input logic [LED_W-1:0] pat,
                                                input logic             d);
        if (d == DIR_LEFT)
            return {pat[LED_W-2:0], pat[LED_W-1]};
        else
            return {pat[0], pat[LED_W-1:1]};
    endfunction

endpackage

// File: rtl/led_shift_ctrl_if.sv
// Remote command channel: valid/ready handshake carrying opcode and operand.
interface led_shift_ctrl_if;
    import led_ctrl_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [OP_W-1:0]    cmd_op;
    logic [LED_W-1:0]   cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);

endinterface

// File: rtl/led_tick_gen.sv
// Rotation period counter: wraps and fires tick after P = QUARTER << speed cycles.
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [SPEED_W-1:0] speed,
    output logic               tick
);

    localparam int QUARTER = CLK_FREQ / 4;
    localparam int CNT_W   = $clog2(2 * CLK_FREQ);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;

    // Terminal count for the selected speed; computed wide then truncated.
    always_comb begin
        last = CNT_W'((QUARTER << speed) - 1);
    end

    assign tick = enable && (cnt == last);

    // Counter holds at zero while disabled or cleared, wraps on terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || !enable || tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/led_shift_ctrl.sv
// Command-driven rotating LED pattern controller.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_STOPPED | automatic rotation off, tick counter held at 0
// ST_RUNNING | tick counter runs, pattern rotates every P cycles
module led_shift_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    led_shift_ctrl_if.slave   cmd,
    output logic [LED_W-1:0]  leds,
    output logic              running,
    output logic              dir,
    output logic              shift_pulse
);

    ctrl_state_e        state_q, state_d;
    logic               ready_q;
    logic [OP_W-1:0]    pend_op_q;
    logic [LED_W-1:0]   pend_data_q;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic               dir_q, dir_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               pulse_q, pulse_d;
    logic               clear;
    logic               tick;
    logic               accept;
    logic               apply;

    // ready is low exactly in the cycle after an accept, which is the apply cycle
    assign accept = cmd.cmd_valid && ready_q;
    assign apply  = !ready_q;

    led_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .enable (state_q == ST_RUNNING),
        .speed  (speed_q),
        .tick   (tick)
    );

    // Command capture and handshake; reset drops any pending command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b1;
            pend_op_q   <= OP_NOP;
            pend_data_q <= '0;
        end else begin
            ready_q <= !accept;
            if (accept) begin
                pend_op_q   <= cmd.cmd_op;
                pend_data_q <= cmd.cmd_data;
            end
        end
    end

    // State, pattern and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUNNING;
            leds_q  <= RESET_PATTERN;
            dir_q   <= DIR_LEFT;
            speed_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            pulse_q <= pulse_d;
        end
    end

    // Apply the pending command and decide whether a coincident tick survives.
    always_comb begin
        state_d = state_q;
        leds_d  = leds_q;
        dir_d   = dir_q;
        speed_d = speed_q;
        pulse_d = 1'b0;
        clear   = 1'b0;

        if (apply) begin
            case (pend_op_q)
                OP_LOAD: begin
                    leds_d = pend_data_q;
                    clear  = 1'b1;
                end
                OP_RUN: begin
                    state_d = ST_RUNNING;
                    if (tick) begin
                        leds_d  = rotate(leds_q, dir_q);
                        pulse_d = 1'b1;
                    end
                end
                OP_STOP: begin
                    state_d = ST_STOPPED;
                    clear   = 1'b1;
                end
                OP_STEP: begin
                    leds_d  = rotate(leds_q, dir_q);
                    pulse_d = 1'b1;
                    clear   = 1'b1;
                end
                OP_SET_DIR: begin
                    dir_d = pend_data_q[0];
                    // a coincident tick already uses the new direction
                    if (tick) begin
                        leds_d  = rotate(leds_q, pend_data_q[0]);
                        pulse_d = 1'b1;
                    end
                end
                OP_SET_SPEED: begin
                    speed_d = pend_data_q[SPEED_W-1:0];
                    clear   = 1'b1;
                end
                OP_INVERT: begin
                    leds_d = ~leds_q;
                    clear  = 1'b1;
                end
                default: begin
                    if (tick) begin
                        leds_d  = rotate(leds_q, dir_q);
                        pulse_d = 1'b1;
                    end
                end
            endcase
        end else if (tick) begin
            leds_d  = rotate(leds_q, dir_q);
            pulse_d = 1'b1;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign leds          = leds_q;
    assign running       = (state_q == ST_RUNNING);
    assign dir           = dir_q;
    assign shift_pulse   = pulse_q;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Directed bench for led_shift_ctrl with CLK_FREQ = 8 (P = 2 at speed 0).
module tb_led_shift_ctrl;
    import led_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] leds;
    logic       running;
    logic       dir;
    logic       shift_pulse;

    int vectors = 0;
    int errors  = 0;

    led_shift_ctrl_if cmd_if ();

    led_shift_ctrl #(
        .CLK_FREQ (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd_if),
        .leds        (leds),
        .running     (running),
        .dir         (dir),
        .shift_pulse (shift_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        cmd_if.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_leds", leds, 8'h1F);
        check("rst_running", {7'd0, running}, 8'd1);
        check("rst_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);
        check("rst_dir", {7'd0, dir}, 8'd0);
        check("rst_pulse", {7'd0, shift_pulse}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge following the apply edge.
    task automatic send(input logic [2:0] op, input logic [7:0] data);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        check("ready_at_offer", {7'd0, cmd_if.cmd_ready}, 8'd1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("ready_in_apply", {7'd0, cmd_if.cmd_ready}, 8'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_leds  [8];
        logic       exp_pulse [8];
        exp_leds  = '{8'h1F, 8'h3E, 8'h3E, 8'h7C, 8'h7C, 8'hF8, 8'hF8, 8'hF1};
        exp_pulse = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        cmd_if.cmd_data  = 8'h00;
        @(negedge clk);

        // Free-running rotation from reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("free_leds", leds, exp_leds[i]);
            check("free_pulse", {7'd0, shift_pulse}, {7'd0, exp_pulse[i]});
        end

        // STOP holds the pattern, STEP rotates once each
        do_reset();
        send(OP_STOP, 8'h00);
        check("stop_leds", leds, 8'h1F);
        check("stop_running", {7'd0, running}, 8'd0);
        repeat (10) @(negedge clk);
        check("stopped_leds", leds, 8'h1F);
        check("stopped_pulse", {7'd0, shift_pulse}, 8'd0);
        send(OP_STEP, 8'h00);
        check("step1_leds", leds, 8'h3E);
        check("step1_pulse", {7'd0, shift_pulse}, 8'd1);
        @(negedge clk);
        check("step1_pulse_end", {7'd0, shift_pulse}, 8'd0);
        send(OP_STEP, 8'h00);
        check("step2_leds", leds, 8'h7C);
        send(OP_INVERT, 8'h00);
        check("invert_leds", leds, 8'h83);
        check("invert_pulse", {7'd0, shift_pulse}, 8'd0);
        send(OP_LOAD, 8'hFF);
        send(OP_STEP, 8'h00);
        check("step_ff", leds, 8'hFF);
        send(OP_LOAD, 8'h00);
        send(OP_STEP, 8'h00);
        check("step_00", leds, 8'h00);
        send(OP_RUN, 8'h00);
        check("run_running", {7'd0, running}, 8'd1);

        // SET_DIR coincides with a tick and rotates right immediately
        do_reset();
        send(OP_SET_DIR, 8'h01);
        check("setdir_leds", leds, 8'h8F);
        check("setdir_dir", {7'd0, dir}, 8'd1);
        check("setdir_pulse", {7'd0, shift_pulse}, 8'd1);
        repeat (2) @(negedge clk);
        check("right_leds", leds, 8'hC7);

        // LOAD then SET_SPEED 2: period becomes 8
        do_reset();
        send(OP_LOAD, 8'h81);
        check("load_leds", leds, 8'h81);
        send(OP_SET_SPEED, 8'h02);
        check("speed_apply_leds", leds, 8'h81);
        repeat (7) @(negedge clk);
        check("speed_hold_leds", leds, 8'h81);
        check("speed_hold_pulse", {7'd0, shift_pulse}, 8'd0);
        @(negedge clk);
        check("speed_rot_leds", leds, 8'h03);
        check("speed_rot_pulse", {7'd0, shift_pulse}, 8'd1);

        // Valid held 4 cycles with distinct ops: only the 1st and 3rd are taken
        do_reset();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op = OP_LOAD;     cmd_if.cmd_data = 8'h3C;
        check("burst_ready0", {7'd0, cmd_if.cmd_ready}, 8'd1);
        @(negedge clk);
        cmd_if.cmd_op = OP_INVERT;   cmd_if.cmd_data = 8'h00;
        check("burst_ready1", {7'd0, cmd_if.cmd_ready}, 8'd0);
        @(negedge clk);
        cmd_if.cmd_op = OP_SET_DIR;  cmd_if.cmd_data = 8'h01;
        check("burst_ready2", {7'd0, cmd_if.cmd_ready}, 8'd1);
        check("burst_load", leds, 8'h3C);
        @(negedge clk);
        cmd_if.cmd_op = OP_LOAD;     cmd_if.cmd_data = 8'hFF;
        check("burst_ready3", {7'd0, cmd_if.cmd_ready}, 8'd0);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("burst_leds", leds, 8'h1E);
        check("burst_dir", {7'd0, dir}, 8'd1);
        check("burst_pulse", {7'd0, shift_pulse}, 8'd1);
        @(negedge clk);
        check("burst_after_leds", leds, 8'h1E);
        check("burst_after_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);

        // Async reset with a LOAD pending
        do_reset();
        repeat (2) @(negedge clk);
        check("pre_rst_leds", leds, 8'h3E);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_LOAD;
        cmd_if.cmd_data  = 8'hAA;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("pend_ready", {7'd0, cmd_if.cmd_ready}, 8'd0);
        rst_n = 1'b0;
        #1;
        check("async_leds", leds, 8'h1F);
        check("async_running", {7'd0, running}, 8'd1);
        check("async_ready", {7'd0, cmd_if.cmd_ready}, 8'd1);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("dropped_leds", leds, 8'h1F);
        @(negedge clk);
        check("post_rst_rot", leds, 8'h3E);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
